// File: rtl/exc_request_gen.sv
// Exception request generator: latches device edge events and issues them
// one at a time as one-hot requests to CP0, holding off until eret.
module exc_request_gen #(
  parameter int NSRC        = 3,
  parameter int ACK_TIMEOUT = 64,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NSRC-1:0]   evt,
  input  logic [NSRC-1:0]   mask,
  input  logic              ack,
  input  logic              eret,
  input  logic              err_clr,
  output logic [NSRC-1:0]   expsrc,
  output logic              busy,
  output logic [1:0]        cur_id,
  output logic [NSRC-1:0]   pending,
  output logic              timeout,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int WCW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(ACK_TIMEOUT - 1);
  localparam int SW = DROP_W + 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]      state;
  logic [NSRC-1:0] evt_q;
  logic [WCW-1:0]  wcnt;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] drop_vec;
  logic [NSRC-1:0] pending_nx;
  logic [NSRC-1:0] win_oh;
  logic [1:0]      win_id;
  logic [1:0]      drop_n;
  logic [SW-1:0]   drop_sum;
  logic            mask_hit;
  logic            in_req;

  assign rise = evt & ~evt_q;
  assign elig = pending & ~mask;
  assign in_req = (state == S_REQ);

  // In REQ, expsrc is exactly the one-hot of cur_id.
  assign clr_vec  = (in_req && ack) ? expsrc : '0;
  assign mask_hit = |(mask & expsrc);

  assign pending_nx = (pending & ~clr_vec) | rise;
  assign drop_vec   = rise & pending & ~clr_vec;

  assign busy = (state == S_SERVICE);

  always_comb begin
    win_id = 2'd0;
    win_oh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id    = 2'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    drop_n = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      drop_n = drop_n + 2'(drop_vec[i]);
    end
    drop_sum = SW'(drop_cnt) + SW'(drop_n);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      evt_q    <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      evt_q   <= evt;
      pending <= pending_nx;
      if (|drop_sum[SW-1:DROP_W]) begin
        drop_cnt <= '1;
      end else begin
        drop_cnt <= drop_sum[DROP_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_IDLE;
      expsrc  <= '0;
      cur_id  <= 2'd0;
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      // A timeout set below overrides this clear.
      if (err_clr) begin
        timeout <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (|elig) begin
            cur_id <= win_id;
            expsrc <= win_oh;
            wcnt   <= '0;
            state  <= S_REQ;
          end else begin
            expsrc <= '0;
          end
        end
        S_REQ: begin
          if (ack) begin
            expsrc <= '0;
            state  <= S_SERVICE;
          end else if (mask_hit) begin
            expsrc <= '0;
            state  <= S_IDLE;
          end else if (wcnt == WC_LAST) begin
            expsrc  <= '0;
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        S_SERVICE: begin
          expsrc <= '0;
          if (eret) begin
            state <= S_IDLE;
          end
        end
        default: begin
          expsrc <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exc_request_gen.md
# exc_request_gen

Exception request generator: the initiator side of the CP0 exception handshake. It latches edge events from up to three device sources into a pending register and issues them one at a time as one-hot `expsrc` requests to CP0. It holds each request until CP0 acknowledges it, then blocks further requests until the handler executes `eret`. It sits between the peripherals and CP0's `expsrc0..2`, `hasexp`, `iseret` and block-register outputs.

## Interface
- `NSRC`, 3: number of sources; fixed at 3 to match CP0 `expsrc0..2`.
- `ACK_TIMEOUT`, 64: cycles a request may wait for `ack` before it is withdrawn (≥2).
- `DROP_W`, 8: width of the saturating dropped-event counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `evt`  in  3  device event levels; a 0→1 transition marks an event.
- `mask`  in  3  per-source block bits (mirror of CP0 block[2:0]); 1 = do not request.
- `ack`  in  1  exception taken (CP0 `hasexp`), sampled on `clk`.
- `eret`  in  1  handler return strobe (CP0 `iseret` qualified by instruction valid).
- `err_clr`  in  1  clears the sticky `timeout` flag.
- `expsrc`  out  3  registered one-hot request to CP0 `expsrc0..2`.
- `busy`  out  1  1 while in SERVICE.
- `cur_id`  out  2  index of the source being requested or serviced.
- `pending`  out  3  latched unserviced events.
- `timeout`  out  1  sticky: a request was withdrawn without `ack`.
- `drop_cnt`  out  DROP_W  saturating count of events lost to an already-set pending bit.

## Operation
- Edge detect: `evt_q` is registered each cycle. `rise = evt & ~evt_q`. `evt_q` resets to 0, so a level already high at reset release counts as an event.
- Pending: bit i is set on `rise[i]` and cleared on `ack` when `cur_id==i` in REQ. Set has priority over clear in the same cycle, and that case is not a drop.
- Drop: `rise[i]` while `pending[i]` is already 1 and not being cleared increments `drop_cnt` by 1 per cycle. Coincident drops on several sources in one cycle add their count. The counter saturates at all-ones.
- Eligible = `pending & ~mask`. Priority: source 0 is highest, then 1, then 2.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE:
    - If any source is eligible, latch the winner into `cur_id`, set `expsrc` one-hot, clear the wait counter, go to REQ.
    - Otherwise `expsrc=0`.
  - REQ:
    - Hold `expsrc`.
    - `ack`=1: `expsrc←0`, clear `pending[cur_id]`, go to SERVICE.
    - Otherwise, if `mask[cur_id]`=1: `expsrc←0`, go to IDLE. No timeout is flagged and the pending bit is kept.
    - Otherwise, if the wait counter = `ACK_TIMEOUT-1`: `expsrc←0`, `timeout←1`, go to IDLE. The pending bit is kept.
    - Otherwise increment the wait counter.
    - `eret` is ignored in REQ.
  - SERVICE:
    - `busy=1`, `expsrc=0`.
    - `eret`=1 returns to IDLE.
    - `ack` is ignored in SERVICE.
    - New events keep latching into `pending`.
- `ack` in IDLE is ignored.
- `timeout` clears on `err_clr`. A new timeout in the same cycle as `err_clr` wins, so `timeout` stays 1.
- `cur_id` holds its last value in IDLE.

## Timing
- Reset (`clr`=1, asynchronous): state IDLE; `expsrc=0`, `busy=0`, `cur_id=0`, `pending=0`, `timeout=0`, `drop_cnt=0`, `evt_q=0`, wait counter 0. Asserting `clr` mid-request drops `expsrc` immediately, without waiting for a clock edge.
- Event latency: `rise` sampled at edge k sets `pending` after edge k. `expsrc` is asserted after edge k+1 (2 edges). `ack` sampled at edge m gives `expsrc=0` and `busy=1` after edge m.
- Minimum gap between two requests: `eret` at edge e returns to IDLE after edge e. The next `expsrc` rises after edge e+1.
- Timeout: `expsrc` is high for exactly `ACK_TIMEOUT` cycles. It falls at the edge where the counter reaches `ACK_TIMEOUT-1`.
- `ack` and timeout in the same cycle: `ack` wins.
- `ack` and mask in the same cycle: `ack` wins.
- `expsrc` is glitch-free (registered) and has at most one bit set.

## Test plan
- Single event: pulse `evt[1]` with `mask=0`. Expect `expsrc=3'b010` 2 edges later. Assert `ack` 3 cycles later: `expsrc=0`, `busy=1`, `pending=0`. Pulse `eret`: `busy=0`.
- Priority: raise `evt[2]` and `evt[0]` in the same cycle. Expect `expsrc=3'b001` first. After ack+eret, expect `expsrc=3'b100` with `cur_id=2`.
- Masking: `mask=3'b001`, pulse `evt[0]`. Expect no request and `pending=3'b001`. Clear `mask`: request follows 1 edge later. Set `mask[0]` during REQ: withdrawn next edge, no `timeout`.
- Timeout: `ACK_TIMEOUT=4`, event on 0, never ack. Expect `expsrc` high 4 cycles, then 0 with `timeout=1` and `pending[0]=1`. Re-request 1 edge later. `err_clr` → `timeout=0`.
- Drops and saturation: `DROP_W=2`, `mask=3'b111`, 5 edges on `evt[0]` → `drop_cnt=3` (saturated). Edge on `evt[1]` coincident with `ack` of source 1 → `pending[1]=1`, no drop.
- Reset: assert `clr` asynchronously mid-REQ and mid-SERVICE. All outputs go to 0 immediately. With `evt[2]` held high through reset release, expect `pending[2]=1` after the first edge.
